axi_lite_arbiter: RTL and testbench

- N-master to 1-slave AXI4-Lite arbiter for the multicycle core. It lets instruction fetch, load/store and future masters (DMA, debug) share one memory port.
- Generalises the current single-master fetch/LSU memory handshakes: parametrised master count and address/data widths, round-robin fairness, and one outstanding transaction tracked through its response.
- Sits between the IFU/LSU AXI-Lite master ports and the memory/crossbar slave port.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_arbiter_rr_arbiter.sv | 34 +++
 rtl/axi_lite_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite arbiter: FSM state encoding and response codes.
// Also provides the index-width helper used to size grant_id.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // A single master still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
// Zero latency; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 1; k <= N; k++) begin
            j  = (int'(last_i) + k) % N;
            jj = IW'(j);
            if (!found && req_i[jj]) begin
                found     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter, one transaction outstanding, round-robin grant.
// Grant costs one IDLE cycle; slave ready/valid pass straight through to the granted master only.
import axi_lite_pkg::*;

module axi_lite_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int STRB_W   = DATA_W / 8,
    localparam int IW       = idx_width(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_arvalid,
    output logic [N_MASTERS-1:0]          m_arready,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
    output logic [N_MASTERS-1:0]          m_rvalid,
    input  logic [N_MASTERS-1:0]          m_rready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [1:0]                    m_rresp,
    input  logic [N_MASTERS-1:0]          m_awvalid,
    output logic [N_MASTERS-1:0]          m_awready,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
    input  logic [N_MASTERS-1:0]          m_wvalid,
    output logic [N_MASTERS-1:0]          m_wready,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
    output logic [N_MASTERS-1:0]          m_bvalid,
    input  logic [N_MASTERS-1:0]          m_bready,
    output logic [1:0]                    m_bresp,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    output logic [ADDR_W-1:0]             s_araddr,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    input  logic [1:0]                    s_bresp,
    output logic                          busy,
    output logic [IW-1:0]                 grant_id
);

    state_e               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] win_gnt;
    logic [IW-1:0]        win_idx;
    logic                 aw_hs, w_hs;

    assign req = m_arvalid | m_awvalid;

    rr_arbiter #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_rr (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (win_gnt),
        .idx_o  (win_idx)
    );

    // Payload muxes follow the registered grant; masters hold them stable while valid.
    assign s_araddr = m_araddr[grant_q*ADDR_W +: ADDR_W];
    assign s_awaddr = m_awaddr[grant_q*ADDR_W +: ADDR_W];
    assign s_wdata  = m_wdata[grant_q*DATA_W +: DATA_W];
    assign s_wstrb  = m_wstrb[grant_q*STRB_W +: STRB_W];
    assign m_rdata  = s_rdata;
    assign m_rresp  = s_rresp;
    assign m_bresp  = s_bresp;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        m_arready = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|win_gnt) begin
                    grant_d = win_idx;
                    last_d  = win_idx;
                    state_d = m_awvalid[win_idx] ? WR_AW : RD_A;
                end
            end
            RD_A: begin
                s_arvalid          = 1'b1;
                m_arready[grant_q] = s_arready;
                if (s_arready) state_d = RD_D;
            end
            RD_D: begin
                s_rready          = m_rready[grant_q];
                m_rvalid[grant_q] = s_rvalid;
                if (s_rvalid && m_rready[grant_q]) state_d = IDLE;
            end
            WR_AW: begin
                // AW and W complete independently; each done flag masks its channel.
                s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
                s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
                m_awready[grant_q] = s_awready & ~aw_done_q;
                m_wready[grant_q]  = s_wready & ~w_done_q;
                aw_hs              = s_awvalid & s_awready;
                w_hs               = s_wvalid & s_wready;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            WR_B: begin
                s_bready          = m_bready[grant_q];
                m_bvalid[grant_q] = s_bvalid;
                if (s_bvalid && m_bready[grant_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= IW'(N_MASTERS - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with two masters; slave side driven by hand per scenario.
module tb_axi_lite_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N*AW-1:0] m_araddr, m_awaddr;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp, m_bresp;
    logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;
    logic [AW-1:0]   s_araddr, s_awaddr;
    logic [DW-1:0]   s_rdata, s_wdata;
    logic [1:0]      s_rresp, s_bresp;
    logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [SW-1:0]   s_wstrb;
    logic            busy;
    logic [0:0]      grant_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .busy(busy), .grant_id(grant_id)
    );

    logic [14:0] hs_vec;
    assign hs_vec = {m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                     s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_araddr = '0; m_rready = '0;
        m_awvalid = '0; m_awaddr = '0; m_wvalid = '0;
        m_wdata = '0; m_wstrb = '0; m_bready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        m_arvalid = 2'b11;
        step();
        probe();
        checks++;
        if (hs_vec !== 15'd0) begin
            errors++; $display("FAIL reset_handshakes: got %h expected 0", hs_vec);
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== 1'b0) begin
            errors++; $display("FAIL reset_busy_grant: busy=%b grant=%b expected 0/0", busy, grant_id);
        end
        step();
        rst = 1'b1;
        probe();
        checks++;
        if (s_arvalid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_first_cycle_idle: arvalid=%b busy=%b expected 0/0", s_arvalid, busy);
        end
        step();
        probe();
        checks++;
        if (s_arvalid !== 1'b1 || grant_id !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant: arvalid=%b grant=%b busy=%b expected 1/0/1",
                               s_arvalid, grant_id, busy);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        m_arvalid = 2'b01; m_araddr[31:0] = 32'h8000_0000; m_rready = 2'b01;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
        step();
        probe();
        checks++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000 || m_arready !== 2'b01) begin
            errors++; $display("FAIL read_addr: arvalid=%b araddr=%h arready=%b expected 1/80000000/01",
                               s_arvalid, s_araddr, m_arready);
        end
        step();
        m_arvalid = 2'b00;
        probe();
        checks++;
        if (m_rvalid !== 2'b01 || m_rdata !== 32'hDEAD_BEEF || m_rresp !== 2'b00 || s_rready !== 1'b1) begin
            errors++; $display("FAIL read_data: rvalid=%b rdata=%h rresp=%b rready=%b expected 01/deadbeef/00/1",
                               m_rvalid, m_rdata, m_rresp, s_rready);
        end
        step();
        s_rvalid = 1'b0;
        probe();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL read_done_idle: busy=%b expected 0", busy);
        end
        do_reset();
    endtask

    task automatic test_fairness();
        m_arvalid = 2'b11; m_rready = 2'b11;
        s_arready = 1'b1; s_rvalid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (s_arvalid !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 10) begin
                errors++; $display("FAIL fair_timeout: txn %0d no s_arvalid within 10 cycles", t);
            end else if (grant_id !== 1'(t % 2)) begin
                errors++; $display("FAIL fair_grant: txn %0d grant=%0d expected %0d", t, grant_id, t % 2);
            end
            @(posedge clk);
        end
        #1;
        do_reset();
    endtask

    task automatic test_write_skew();
        int aw_cnt = 0;
        int w_cnt = 0;
        logic bad_ready = 1'b0;
        m_awvalid = 2'b10; m_awaddr[63:32] = 32'h0000_1000;
        m_wvalid = 2'b10; m_wdata[63:32] = 32'h55AA_55AA; m_wstrb[7:4] = 4'hF;
        m_bready = 2'b10;
        step();
        for (int c = 0; c < 3; c++) begin
            s_awready = (c == 2);
            s_wready = 1'b1;
            probe();
            if (s_awvalid && s_awready) aw_cnt++;
            if (s_wvalid && s_wready) w_cnt++;
            if (m_awready[0] || m_wready[0]) bad_ready = 1'b1;
            if (c == 0) begin
                checks++;
                if (s_awaddr !== 32'h1000 || s_wdata !== 32'h55AA_55AA || s_wstrb !== 4'hF) begin
                    errors++; $display("FAIL write_payload: awaddr=%h wdata=%h wstrb=%h expected 1000/55aa55aa/f",
                                       s_awaddr, s_wdata, s_wstrb);
                end
            end
            step();
        end
        s_awready = 1'b0; s_wready = 1'b0;
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        s_bvalid = 1'b1; s_bresp = 2'b00;
        probe();
        checks++;
        if (aw_cnt != 1 || w_cnt != 1 || bad_ready) begin
            errors++; $display("FAIL write_handshakes: aw=%0d w=%0d m0_ready=%b expected 1/1/0",
                               aw_cnt, w_cnt, bad_ready);
        end
        checks++;
        if (m_bvalid !== 2'b10 || grant_id !== 1'b1) begin
            errors++; $display("FAIL write_bvalid: bvalid=%b grant=%b expected 10/1", m_bvalid, grant_id);
        end
        step();
        s_bvalid = 1'b0;
        probe();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL write_done_idle: busy=%b expected 0", busy);
        end
        do_reset();
    endtask

    task automatic test_write_then_read();
        logic bp_bad = 1'b0;
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_arvalid = 2'b01;
        m_awaddr[31:0] = 32'h2000; m_araddr[31:0] = 32'h3000; m_wdata[31:0] = 32'h0BAD_F00D;
        m_wstrb[3:0] = 4'h3; m_bready = 2'b01;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_arready = 1'b1;
        step();
        probe();
        checks++;
        if (s_awvalid !== 1'b1 || s_wvalid !== 1'b1 || s_arvalid !== 1'b0 || s_awaddr !== 32'h2000) begin
            errors++; $display("FAIL wr_first: awvalid=%b wvalid=%b arvalid=%b awaddr=%h expected 1/1/0/2000",
                               s_awvalid, s_wvalid, s_arvalid, s_awaddr);
        end
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        probe();
        checks++;
        if (m_bvalid !== 2'b01 || s_bready !== 1'b1) begin
            errors++; $display("FAIL wr_resp: bvalid=%b bready=%b expected 01/1", m_bvalid, s_bready);
        end
        step();
        s_bvalid = 1'b0;
        step();
        probe();
        checks++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000 || grant_id !== 1'b0) begin
            errors++; $display("FAIL rd_after_wr: arvalid=%b araddr=%h grant=%b expected 1/3000/0",
                               s_arvalid, s_araddr, grant_id);
        end
        step();
        m_arvalid = 2'b00; m_rready = 2'b00;
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            probe();
            if (s_rready !== 1'b0 || m_rvalid !== 2'b01 || m_rdata !== 32'h1234_5678) bp_bad = 1'b1;
            step();
        end
        checks++;
        if (bp_bad || busy !== 1'b1) begin
            errors++; $display("FAIL rd_backpressure: stall_violation=%b busy=%b expected 0/1", bp_bad, busy);
        end
        m_rready = 2'b01;
        probe();
        checks++;
        if (s_rready !== 1'b1) begin
            errors++; $display("FAIL rd_release: rready=%b expected 1", s_rready);
        end
        step();
        s_rvalid = 1'b0;
        probe();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rd_done_idle: busy=%b expected 0", busy);
        end
        do_reset();
    endtask

    task automatic test_slverr_and_reset();
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_awaddr[63:32] = 32'h4000; m_bready = 2'b10;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b10;
        step();
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        probe();
        checks++;
        if (m_bvalid !== 2'b10 || m_bresp !== 2'b10) begin
            errors++; $display("FAIL slverr_resp: bvalid=%b bresp=%b expected 10/10", m_bvalid, m_bresp);
        end
        step();
        s_bvalid = 1'b0; s_bresp = 2'b00;
        m_arvalid = 2'b01; m_rready = 2'b01; s_arready = 1'b1; s_rvalid = 1'b0;
        step();
        step();
        m_arvalid = 2'b00;
        probe();
        checks++;
        if (busy !== 1'b1 || s_rready !== 1'b1 || grant_id !== 1'b0) begin
            errors++; $display("FAIL rd_d_before_reset: busy=%b rready=%b grant=%b expected 1/1/0",
                               busy, s_rready, grant_id);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hs_vec !== 15'd0) begin
            errors++; $display("FAIL async_reset: busy=%b handshakes=%h expected 0/0", busy, hs_vec);
        end
        step();
        rst = 1'b1;
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_single_read();
        test_fairness();
        test_write_skew();
        test_write_then_read();
        test_slverr_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
